// File: rtl/rv32_pkg.sv
// Shared RV32I definitions for the load/store path: funct3 codes, LSU state
// encoding and the op legality check.
package rv32_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } lsu_state_e;

  // An op is legal only if exactly one of load/store is set and funct3 fits it.
  function automatic logic op_illegal(input logic is_load, input logic is_store,
                                      input logic [2:0] f3);
    logic ld_ok;
    logic st_ok;
    ld_ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
            (f3 == F3_LBU) || (f3 == F3_LHU);
    st_ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (is_load == is_store) || (is_load && !ld_ok) || (is_store && !st_ok);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic: store byte enables and replication, load byte/half
// extraction with sign/zero extension, and natural-alignment check.
module lsu_align
  import rv32_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic        misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = mem_rdata[{addr_lo, 3'b000} +: 8];
  assign w_half = mem_rdata[{addr_lo[1], 4'b0000} +: 16];

  // funct3[1:0] carries the access size; funct3[2] selects zero extension.
  always_comb begin
    be         = 4'b0000;
    wdata      = 32'h0;
    load_ext   = 32'h0;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be       = 4'(4'b0001 << addr_lo);
        wdata    = {4{store_data[7:0]}};
        load_ext = funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      2'b01: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        load_ext   = funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
        misaligned = addr_lo[0];
      end
      2'b10: begin
        be         = 4'b1111;
        wdata      = store_data;
        load_ext   = mem_rdata;
        misaligned = (addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_unit.sv
// RV32I load/store unit: one data-memory transaction per start, with
// req/ready handshake, fault detection and handshake timeout.
module lsu_unit
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  output logic [31:0] load_data,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic        illegal,
  output logic        timeout
);

  localparam int unsigned CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

  lsu_state_e        r_state;
  lsu_state_e        w_next;
  logic [31:0]       r_addr;
  logic [2:0]        r_funct3;
  logic              r_is_load;
  logic              r_we;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_load_data;
  logic              r_ill;
  logic              r_mis;
  logic              r_to;
  logic [CNT_W-1:0]  r_cnt;

  logic [2:0]        w_f3;
  logic [1:0]        w_alo;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_ext;
  logic              w_al_mis;
  logic              w_illegal;
  logic              w_fault;
  logic              w_to_hit;

  // Lane logic sees the live op while idle and the captured op afterwards.
  assign w_f3  = (r_state == IDLE) ? funct3 : r_funct3;
  assign w_alo = (r_state == IDLE) ? addr[1:0] : r_addr[1:0];

  lsu_align u_align (
    .funct3     (w_f3),
    .addr_lo    (w_alo),
    .store_data (store_data),
    .mem_rdata  (mem_rdata),
    .be         (w_be),
    .wdata      (w_wdata),
    .load_ext   (w_load_ext),
    .misaligned (w_al_mis)
  );

  assign w_illegal = op_illegal(is_load, is_store, funct3);
  assign w_fault   = w_illegal | w_al_mis;
  assign w_to_hit  = TO_EN && !mem_ready && (r_cnt == CNT_W'(TO_LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = w_fault ? ERR : REQ;
      REQ: begin
        if (mem_ready)     w_next = DONE;
        else if (w_to_hit) w_next = ERR;
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Transaction capture, handshake counter and load result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= 32'h0;
      r_funct3    <= 3'b000;
      r_is_load   <= 1'b0;
      r_we        <= 1'b0;
      r_be        <= 4'b0000;
      r_wdata     <= 32'h0;
      r_load_data <= 32'h0;
      r_ill       <= 1'b0;
      r_mis       <= 1'b0;
      r_to        <= 1'b0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_addr    <= addr;
            r_funct3  <= funct3;
            r_is_load <= is_load;
            r_we      <= is_store & ~is_load;
            r_be      <= is_load ? 4'b1111 : w_be;
            r_wdata   <= is_load ? 32'h0 : w_wdata;
            r_ill     <= w_illegal;
            r_mis     <= ~w_illegal & w_al_mis;
            r_to      <= 1'b0;
            r_cnt     <= '0;
          end
        end
        REQ: begin
          if (mem_ready) begin
            if (r_is_load) r_load_data <= w_load_ext;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_to_hit) r_to <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state so they clear with async reset.
  always_comb begin
    mem_req    = (r_state == REQ);
    busy       = (r_state != IDLE);
    done       = (r_state == DONE) || (r_state == ERR);
    misaligned = done & r_mis;
    illegal    = done & r_ill;
    timeout    = done & r_to;
    mem_we     = r_we;
    mem_addr   = {r_addr[31:2], 2'b00};
    mem_be     = r_be;
    mem_wdata  = r_wdata;
    load_data  = r_load_data;
  end

endmodule
